// File: rtl/hazard_unit_p.sv
// Pipeline hazard unit: EX operand forwarding, load-use / RAW stall detection,
// multi-cycle EX occupancy FSM and registered PC redirect with follow-up flush.
module hazard_unit_p #(
   parameter int XLEN   = 32,
   parameter int RA_W   = 5,
   parameter int MC_LAT = 4,
   parameter int FWD_EN = 1
) (
   input  logic            clk,
   input  logic            rst,
   // IF/ID sources
   input  logic [RA_W-1:0] id_rs1,
   input  logic [RA_W-1:0] id_rs2,
   input  logic            id_use_rs1,
   input  logic            id_use_rs2,
   // ID/EX stage
   input  logic [RA_W-1:0] ex_rs1,
   input  logic [RA_W-1:0] ex_rs2,
   input  logic [RA_W-1:0] ex_rd,
   input  logic            ex_valid,
   input  logic            ex_wen,
   input  logic            ex_is_load,
   input  logic            ex_is_mc,
   // Later-stage producers
   input  logic [RA_W-1:0] mem_rd,
   input  logic [RA_W-1:0] wb_rd,
   input  logic            mem_wen,
   input  logic            wb_wen,
   input  logic [XLEN-1:0] mem_result,
   input  logic [XLEN-1:0] wb_result,
   input  logic [XLEN-1:0] ex_rdata1,
   input  logic [XLEN-1:0] ex_rdata2,
   // EX-stage branch resolution
   input  logic            br_taken_ex,
   input  logic [XLEN-1:0] br_target_ex,
   // Results
   output logic [XLEN-1:0] ex_src_a,
   output logic [XLEN-1:0] ex_src_b,
   output logic            jump_en,
   output logic [XLEN-1:0] jump_addr,
   output logic            stall_if,
   output logic            stall_id,
   output logic            stall_ex,
   output logic            flush_if,
   output logic            flush_id,
   output logic            flush_ex,
   output logic            mc_busy
);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} mc_state_t;

   // The start cycle counts as the first EX cycle, so the counter covers the rest minus the exit cycle.
   localparam logic [3:0] CNT_INIT = 4'(MC_LAT - 2);

   mc_state_t       state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            jump_en_q, jump_en_d;
   logic [XLEN-1:0] jump_addr_q, jump_addr_d;
   logic            flush_pend_q, flush_pend_d;

   logic            redirect;
   logic            mc_start;
   logic            mc_stall;
   logic            load_use;
   logic            raw_stall;
   logic            hz_stall;

   // ---------------------------------------------------------------------
   // Operand forwarding, one lane per EX source operand
   // ---------------------------------------------------------------------
   logic [RA_W-1:0] ex_rs    [2];
   logic [XLEN-1:0] ex_rdata [2];
   logic [XLEN-1:0] ex_src   [2];

   assign ex_rs[0]    = ex_rs1;
   assign ex_rs[1]    = ex_rs2;
   assign ex_rdata[0] = ex_rdata1;
   assign ex_rdata[1] = ex_rdata2;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         if (FWD_EN != 0) begin : g_on
            logic hit_mem;
            logic hit_wb;
            // MEM is the younger producer, so it wins over WB; x0 never forwards.
            assign hit_mem    = mem_wen && (mem_rd != '0) && (mem_rd == ex_rs[gi]);
            assign hit_wb     = wb_wen  && (wb_rd  != '0) && (wb_rd  == ex_rs[gi]);
            assign ex_src[gi] = hit_mem ? mem_result :
                                hit_wb  ? wb_result  : ex_rdata[gi];
         end else begin : g_off
            assign ex_src[gi] = ex_rdata[gi];
         end
      end
   endgenerate

   assign ex_src_a = ex_src[0];
   assign ex_src_b = ex_src[1];

   // ---------------------------------------------------------------------
   // Producer match against the ID-stage sources (EX, MEM, WB)
   // ---------------------------------------------------------------------
   logic [RA_W-1:0] prod_rd  [3];
   logic [2:0]      prod_wen;
   logic [2:0]      prod_hit;

   assign prod_rd[0]  = ex_rd;
   assign prod_rd[1]  = mem_rd;
   assign prod_rd[2]  = wb_rd;
   assign prod_wen[0] = ex_valid && ex_wen;
   assign prod_wen[1] = mem_wen;
   assign prod_wen[2] = wb_wen;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_hit
         assign prod_hit[gi] = prod_wen[gi] && (prod_rd[gi] != '0) &&
                               ((id_use_rs1 && (id_rs1 == prod_rd[gi])) ||
                                (id_use_rs2 && (id_rs2 == prod_rd[gi])));
      end
   endgenerate

   assign load_use = prod_hit[0] && ex_is_load;

   generate
      if (FWD_EN != 0) begin : g_raw_fwd
         assign raw_stall = 1'b0;
      end else begin : g_raw_stall
         // Without forwarding any in-flight writer of a needed register holds ID.
         assign raw_stall = |prod_hit;
      end
   endgenerate

   assign redirect = ex_valid && br_taken_ex;
   assign mc_start = ex_valid && ex_is_mc && !br_taken_ex;

   // ---------------------------------------------------------------------
   // Multi-cycle FSM
   // ---------------------------------------------------------------------

   // State and redirect registers, cleared immediately by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         jump_en_q    <= 1'b0;
         jump_addr_q  <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         jump_en_q    <= jump_en_d;
         jump_addr_q  <= jump_addr_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   // Next-state: start counts down MC_LAT-2 busy cycles, then the op leaves EX.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      jump_en_d    = redirect;
      flush_pend_d = redirect;
      jump_addr_d  = redirect ? br_target_ex : jump_addr_q;
      case (state_q)
         S_IDLE: begin
            if (mc_start) begin
               state_d = S_BUSY;
               cnt_d   = CNT_INIT;
            end
         end
         S_BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Outputs: MC stall dominates data hazards; a redirect cancels them too.
   always_comb begin
      mc_stall = rst && (((state_q == S_IDLE) && mc_start) ||
                         ((state_q == S_BUSY) && (cnt_q != 4'd0)));
      hz_stall = (load_use || raw_stall) && !redirect && !mc_stall;
      stall_if = mc_stall || hz_stall;
      stall_id = mc_stall || hz_stall;
      stall_ex = mc_stall;
      mc_busy  = mc_stall;
      flush_ex = hz_stall;
      flush_id = redirect;
      flush_if = redirect || (rst && flush_pend_q);
   end

   assign jump_en   = jump_en_q;
   assign jump_addr = jump_addr_q;

endmodule

// File: tb/tb_hazard_unit_p.sv
// Scoreboard bench for hazard_unit_p: three instances (default, MC_LAT=2,
// FWD_EN=0) share stimulus; each expectation names the instance it checks.
module tb_hazard_unit_p;

   localparam int XLEN = 32;
   localparam int RA_W = 5;

   localparam logic [31:0] R1  = 32'h1111_1111;
   localparam logic [31:0] R2  = 32'h2222_2222;
   localparam logic [31:0] MEM = 32'hAAAA_0001;
   localparam logic [31:0] WB  = 32'h0000_0005;

   // {stall_if, stall_id, stall_ex, flush_if, flush_id, flush_ex, mc_busy}
   localparam logic [6:0] F_NONE = 7'b000_0000;
   localparam logic [6:0] F_LU   = 7'b110_0010;
   localparam logic [6:0] F_MC   = 7'b111_0001;
   localparam logic [6:0] F_BR   = 7'b000_1100;
   localparam logic [6:0] F_PEND = 7'b000_1000;
   localparam logic [6:0] F_MCBR = 7'b111_1101;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [RA_W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic            id_use_rs1, id_use_rs2, ex_valid, ex_wen, ex_is_load, ex_is_mc;
   logic            mem_wen, wb_wen, br_taken_ex;
   logic [XLEN-1:0] mem_result, wb_result, ex_rdata1, ex_rdata2, br_target_ex;

   logic [XLEN-1:0] src_a_w [3];
   logic [XLEN-1:0] src_b_w [3];
   logic [XLEN-1:0] jaddr_w [3];
   logic [2:0]      jen_w, sif_w, sid_w, sex_w, fif_w, fid_w, fex_w, mcb_w;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dut
         hazard_unit_p #(
            .XLEN  (XLEN),
            .RA_W  (RA_W),
            .MC_LAT((gi == 1) ? 2 : 4),
            .FWD_EN((gi == 2) ? 0 : 1)
         ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .id_rs1      (id_rs1),
            .id_rs2      (id_rs2),
            .id_use_rs1  (id_use_rs1),
            .id_use_rs2  (id_use_rs2),
            .ex_rs1      (ex_rs1),
            .ex_rs2      (ex_rs2),
            .ex_rd       (ex_rd),
            .ex_valid    (ex_valid),
            .ex_wen      (ex_wen),
            .ex_is_load  (ex_is_load),
            .ex_is_mc    (ex_is_mc),
            .mem_rd      (mem_rd),
            .wb_rd       (wb_rd),
            .mem_wen     (mem_wen),
            .wb_wen      (wb_wen),
            .mem_result  (mem_result),
            .wb_result   (wb_result),
            .ex_rdata1   (ex_rdata1),
            .ex_rdata2   (ex_rdata2),
            .br_taken_ex (br_taken_ex),
            .br_target_ex(br_target_ex),
            .ex_src_a    (src_a_w[gi]),
            .ex_src_b    (src_b_w[gi]),
            .jump_en     (jen_w[gi]),
            .jump_addr   (jaddr_w[gi]),
            .stall_if    (sif_w[gi]),
            .stall_id    (sid_w[gi]),
            .stall_ex    (sex_w[gi]),
            .flush_if    (fif_w[gi]),
            .flush_id    (fid_w[gi]),
            .flush_ex    (fex_w[gi]),
            .mc_busy     (mcb_w[gi])
         );
      end
   endgenerate

   typedef struct packed {
      logic [1:0]  dut;
      logic [31:0] a;
      logic [31:0] b;
      logic        je;
      logic [31:0] ja;
      logic [6:0]  flg;
   } exp_t;

   exp_t  exp_q  [$];
   string name_q [$];
   int    total = 0;
   int    bad   = 0;

   // Monitor: pops one expectation per cycle, mid-cycle, and compares.
   always @(negedge clk) begin
      exp_t  e;
      exp_t  act;
      string nm;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         nm  = name_q.pop_front();
         act.dut = e.dut;
         act.a   = src_a_w[e.dut];
         act.b   = src_b_w[e.dut];
         act.je  = jen_w[e.dut];
         act.ja  = jaddr_w[e.dut];
         act.flg = {sif_w[e.dut], sid_w[e.dut], sex_w[e.dut], fif_w[e.dut],
                    fid_w[e.dut], fex_w[e.dut], mcb_w[e.dut]};
         total++;
         if (act !== e) begin
            bad++;
            $display("FAIL %s dut%0d: got a=%h b=%h je=%b ja=%h flags=%b, want a=%h b=%h je=%b ja=%h flags=%b",
                     nm, e.dut, act.a, act.b, act.je, act.ja, act.flg, e.a, e.b, e.je, e.ja, e.flg);
         end else begin
            $display("ok   %s dut%0d: a=%h b=%h je=%b ja=%h flags=%b",
                     nm, e.dut, act.a, act.b, act.je, act.ja, act.flg);
         end
      end
   end

   task automatic clr();
      id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
      ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
      ex_valid = 0; ex_wen = 0; ex_is_load = 0; ex_is_mc = 0;
      mem_rd = '0; wb_rd = '0; mem_wen = 0; wb_wen = 0;
      mem_result = MEM; wb_result = WB; ex_rdata1 = R1; ex_rdata2 = R2;
      br_taken_ex = 0; br_target_ex = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [1:0] d, input logic [31:0] a,
                      input logic [31:0] b, input logic je, input logic [31:0] ja,
                      input logic [6:0] flg);
      exp_t e;
      e.dut = d; e.a = a; e.b = b; e.je = je; e.ja = ja; e.flg = flg;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic set_lu();
      ex_valid = 1; ex_is_load = 1; ex_wen = 1; ex_rd = 5'd7;
      id_rs2 = 5'd7; id_use_rs2 = 1;
   endtask

   initial begin
      rst = 0;
      clr();
      tick();

      // Reset: a presented MC op must not stall while rst is low
      ex_valid = 1; ex_is_mc = 1;
      chk("reset", 0, R1, R2, 0, 0, F_NONE); tick();
      rst = 1;

      // Forwarding priority and register-0 / no-write exclusions
      clr(); ex_rs1 = 3; mem_rd = 3; mem_wen = 1; wb_rd = 3; wb_wen = 1;
      chk("fwd_mem", 0, MEM, R2, 0, 0, F_NONE); tick();
      clr(); ex_rs2 = 4; wb_rd = 4; wb_wen = 1;
      chk("fwd_wb", 0, R1, WB, 0, 0, F_NONE); tick();
      clr(); mem_wen = 1; wb_wen = 1;
      chk("fwd_rd0", 0, R1, R2, 0, 0, F_NONE); tick();
      clr(); ex_rs1 = 3; mem_rd = 3; wb_rd = 3;
      chk("fwd_nowen", 0, R1, R2, 0, 0, F_NONE); tick();

      // Load-use: one cycle, then the bubble in EX clears it
      clr(); set_lu();
      chk("load_use", 0, R1, R2, 0, 0, F_LU); tick();
      ex_valid = 0;
      chk("load_use_bubble", 0, R1, R2, 0, 0, F_NONE); tick();
      clr(); set_lu(); id_use_rs2 = 0;
      chk("load_use_nouse", 0, R1, R2, 0, 0, F_NONE); tick();

      // MC_LAT=4: three stall cycles, released in the fourth
      clr(); ex_valid = 1; ex_is_mc = 1;
      chk("mc_start", 0, R1, R2, 0, 0, F_MC); tick();
      chk("mc_busy1", 0, R1, R2, 0, 0, F_MC); tick();
      chk("mc_busy2", 0, R1, R2, 0, 0, F_MC); tick();
      chk("mc_exit", 0, R1, R2, 0, 0, F_NONE); tick();

      // MC_LAT=2: a single stall cycle
      clr(); tick();
      ex_valid = 1; ex_is_mc = 1;
      chk("mc2_start", 1, R1, R2, 0, 0, F_MC); tick();
      chk("mc2_exit", 1, R1, R2, 0, 0, F_NONE); tick();
      clr(); tick(); tick();

      // Load-use while MC op busy: MC wins, load-use appears at exit
      clr(); ex_is_mc = 1; set_lu();
      chk("lu_mc_start", 0, R1, R2, 0, 0, F_MC); tick();
      chk("lu_mc_busy1", 0, R1, R2, 0, 0, F_MC); tick();
      chk("lu_mc_busy2", 0, R1, R2, 0, 0, F_MC); tick();
      chk("lu_mc_exit", 0, R1, R2, 0, 0, F_LU); tick();
      clr(); tick();

      // Redirect with a load-use hazard present
      clr(); set_lu(); br_taken_ex = 1; br_target_ex = 32'h0000_0100;
      chk("br_n", 0, R1, R2, 0, 0, F_BR); tick();
      clr();
      chk("br_n1", 0, R1, R2, 1, 32'h100, F_PEND); tick();
      chk("br_n2", 0, R1, R2, 0, 32'h100, F_NONE); tick();

      // Back-to-back redirects
      clr(); ex_valid = 1; br_taken_ex = 1; br_target_ex = 32'h0000_0200;
      chk("bb_n", 0, R1, R2, 0, 32'h100, F_BR); tick();
      br_target_ex = 32'h0000_0300;
      chk("bb_n1", 0, R1, R2, 1, 32'h200, F_BR); tick();
      clr();
      chk("bb_n2", 0, R1, R2, 1, 32'h300, F_PEND); tick();
      tick();

      // A taken branch blocks the MC start
      clr(); ex_valid = 1; ex_is_mc = 1; br_taken_ex = 1; br_target_ex = 32'h0000_0400;
      chk("br_mc", 0, R1, R2, 0, 32'h300, F_BR); tick();
      clr();
      chk("br_mc_n1", 0, R1, R2, 1, 32'h400, F_PEND); tick();

      // Asynchronous reset in the second BUSY cycle
      clr(); ex_valid = 1; ex_is_mc = 1;
      chk("rst_mc_start", 0, R1, R2, 0, 32'h400, F_MC); tick();
      br_taken_ex = 1; br_target_ex = 32'h0000_0500;
      chk("rst_mc_busy1", 0, R1, R2, 0, 32'h400, F_MCBR); tick();
      br_taken_ex = 0; br_target_ex = '0; rst = 0;
      chk("rst_async", 0, R1, R2, 0, 0, F_NONE); tick();
      rst = 1; clr();
      chk("rst_release", 0, R1, R2, 0, 0, F_NONE); tick();
      ex_valid = 1; ex_is_mc = 1;
      chk("rst_restart", 0, R1, R2, 0, 0, F_MC); tick();
      clr(); tick(); tick(); tick(); tick();

      // Forwarding disabled: stall until producer leaves WB, no bypass
      clr(); id_rs1 = 5; id_use_rs1 = 1; ex_rs1 = 5; mem_rd = 5; mem_wen = 1;
      chk("nf_mem", 2, R1, R2, 0, 0, F_LU); tick();
      chk("fwd_on_nostall", 0, MEM, R2, 0, 0, F_NONE); tick();
      mem_wen = 0; wb_rd = 5; wb_wen = 1;
      chk("nf_wb", 2, R1, R2, 0, 0, F_LU); tick();
      wb_wen = 0;
      chk("nf_clear", 2, R1, R2, 0, 0, F_NONE); tick();
      ex_valid = 1; ex_wen = 1; ex_rd = 5;
      chk("nf_ex", 2, R1, R2, 0, 0, F_LU); tick();
      clr(); id_use_rs1 = 1; mem_wen = 1; wb_wen = 1;
      chk("nf_rd0", 2, R1, R2, 0, 0, F_NONE); tick();
      clr(); id_rs1 = 5; id_use_rs1 = 1; mem_rd = 5; mem_wen = 1;
      ex_valid = 1; br_taken_ex = 1; br_target_ex = 32'h0000_0600;
      chk("nf_br", 2, R1, R2, 0, 0, F_BR); tick();

      clr(); tick(); tick();
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
